// File: rtl/dmux16_stream.sv
// Buffered 1-to-2 demultiplexer: each word is steered by sel into one of two
// independent FIFO channels (A/B), each with its own valid/ready handshake.
module dmux16_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in16,
  input  logic                     sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         a16,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         b16,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Index 0 is channel A, index 1 is channel B.
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PtrW-1:0]  wr_q  [2];
  logic [PtrW-1:0]  rd_q  [2];
  logic [CntW-1:0]  cnt_q [2];
  logic [CntW-1:0]  cnt_d [2];
  logic [1:0]       full;
  logic [1:0]       vld;
  logic [1:0]       push;
  logic [1:0]       pop;

  always_comb begin
    full = '0;
    vld  = '0;
    for (int c = 0; c < 2; c++) begin
      full[c] = (cnt_q[c] == CntW'(DEPTH));
      vld[c]  = (cnt_q[c] != '0);
    end
  end

  // No bypass: a full channel refuses a push even if it is popped this cycle.
  assign in_ready = !rst && !full[sel];

  assign push[0] = in_valid && in_ready && !sel;
  assign push[1] = in_valid && in_ready && sel;
  assign pop[0]  = !rst && vld[0] && a_ready;
  assign pop[1]  = !rst && vld[1] && b_ready;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cnt_d[c] = cnt_q[c];
      if (push[c] && !pop[c]) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end else if (pop[c] && !push[c]) begin
        cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        cnt_q[c] <= '0;
        wr_q[c]  <= '0;
        rd_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        cnt_q[c] <= cnt_d[c];
        if (push[c]) begin
          wr_q[c] <= wr_q[c] + 1'b1;
        end
        if (pop[c]) begin
          rd_q[c] <= rd_q[c] + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset; outputs are masked while the channel is empty.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_q[c][wr_q[c]] <= in16;
      end
    end
  end

  assign a_valid = vld[0];
  assign b_valid = vld[1];
  assign a16     = vld[0] ? mem_q[0][rd_q[0]] : '0;
  assign b16     = vld[1] ? mem_q[1][rd_q[1]] : '0;
  assign a_count = cnt_q[0];
  assign b_count = cnt_q[1];

endmodule

// File: tb/tb_dmux16_stream.sv
// Directed self-checking bench for dmux16_stream (WIDTH=16, DEPTH=2).
module tb_dmux16_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in16;
  logic        sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a16;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b16;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  a_count;
  logic [1:0]  b_count;

  int checks   = 0;
  int failures = 0;

  dmux16_stream #(
    .WIDTH(16),
    .DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in16     (in16),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a16      (a16),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b16      (b16),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample #1 later so outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, " a_count"}, 32'(a_count), 32'd0);
    check({tag, " b_count"}, 32'(b_count), 32'd0);
    check({tag, " a_valid"}, 32'(a_valid), 32'd0);
    check({tag, " b_valid"}, 32'(b_valid), 32'd0);
    check({tag, " a16"}, 32'(a16), 32'd0);
    check({tag, " b16"}, 32'(b16), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; sel = 1'b0; in16 = 16'hFFFF;
    a_ready = 1'b0; b_ready = 1'b0;

    // 1. reset with in_valid held high
    step();
    step();
    check_empty("reset");
    check("reset in_ready", 32'(in_ready), 32'd0);

    rst = 1'b0; in_valid = 1'b0; sel = 1'b1;
    step();
    check("idle ignored b_count", 32'(b_count), 32'd0);

    // 2. single push to A
    sel = 1'b0; in16 = 16'h1234; in_valid = 1'b1;
    #1 check("t2 in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("t2 a_valid", 32'(a_valid), 32'd1);
    check("t2 a16", 32'(a16), 32'h1234);
    check("t2 a_count", 32'(a_count), 32'd1);
    check("t2 b_valid", 32'(b_valid), 32'd0);

    // 3. fill B, third word must be held
    sel = 1'b1; in_valid = 1'b1; in16 = 16'hAAAA;
    step();
    in16 = 16'hBBBB;
    step();
    check("t3 b_count full", 32'(b_count), 32'd2);
    in16 = 16'hCCCC;
    #1 check("t3 in_ready full", 32'(in_ready), 32'd0);
    step();
    check("t3 b_count held", 32'(b_count), 32'd2);
    check("t3 b16 head", 32'(b16), 32'hAAAA);

    // 4. B stalled, A still accepts
    sel = 1'b0; in16 = 16'h5555;
    #1 check("t4 in_ready A", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("t4 a_count", 32'(a_count), 32'd2);
    check("t4 b_count", 32'(b_count), 32'd2);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    check("t4 a_count pop", 32'(a_count), 32'd1);
    check("t4 a16 next", 32'(a16), 32'h5555);

    // 3 (cont). drain B in order; no bypass while full
    sel = 1'b1; in16 = 16'hCCCC; in_valid = 1'b1; b_ready = 1'b1;
    #1 check("t3 no bypass", 32'(in_ready), 32'd0);
    step();
    check("t3 b16 second", 32'(b16), 32'hBBBB);
    check("t3 b_count 1", 32'(b_count), 32'd1);
    #1 check("t3 in_ready open", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("t3 b16 third", 32'(b16), 32'hCCCC);
    check("t3 b_count pushpop", 32'(b_count), 32'd1);
    step();
    b_ready = 1'b0;
    check("t3 b_valid empty", 32'(b_valid), 32'd0);
    check("t3 b16 zero", 32'(b16), 32'd0);
    check("t3 a16 untouched", 32'(a16), 32'h5555);

    // 5. push+pop on A across the pointer wrap
    sel = 1'b0; in_valid = 1'b1; a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] exp_head;
      exp_head = (i == 0) ? 16'h5555 : 16'(16'h1000 + i - 1);
      in16 = 16'(16'h1000 + i);
      #1 check($sformatf("t5 head %0d", i), 32'(a16), 32'(exp_head));
      step();
      check($sformatf("t5 a_count %0d", i), 32'(a_count), 32'd1);
    end
    in_valid = 1'b0; a_ready = 1'b0;
    check("t5 a16 last", 32'(a16), 32'h1007);

    // 6. reset with A=2, B=1 discards everything
    in_valid = 1'b1; sel = 1'b0; in16 = 16'h2222;
    step();
    sel = 1'b1; in16 = 16'h3333;
    step();
    in_valid = 1'b0;
    check("t6 a_count pre", 32'(a_count), 32'd2);
    check("t6 b_count pre", 32'(b_count), 32'd1);
    rst = 1'b1;
    step();
    check_empty("t6 reset");
    rst = 1'b0;
    step();
    check_empty("t6 after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
